// File: rtl/slc3_stim_pkg.sv
// Shared types and step-word layout helpers for the SLC-3 stimulus player.
// A step word is {op, btn, sw, arg}, with arg in the least significant bits.
// The decoder works on a fixed maximum-width view of the word. That lets one
// function serve any legal parameter set: each field is at most 32 bits, and
// the whole word is at most WORD_MAX bits.
package slc3_stim_pkg;

    typedef enum logic [1:0] {
        OP_END  = 2'b00,
        OP_HOLD = 2'b01,
        OP_WAIT = 2'b10,
        OP_RSVD = 2'b11
    } stim_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT,
        ST_DONE
    } stim_state_t;

    localparam int FIELD_MAX = 32;
    localparam int WORD_MAX  = 2 + 3 * FIELD_MAX;

    typedef struct packed {
        stim_op_t             op;
        logic [FIELD_MAX-1:0] btn;
        logic [FIELD_MAX-1:0] sw;
        logic [FIELD_MAX-1:0] arg;
    } stim_step_t;

    function automatic int sw_lsb(input int arg_w);
        return arg_w;
    endfunction

    function automatic int btn_lsb(input int arg_w, input int sw_w);
        return arg_w + sw_w;
    endfunction

    function automatic int op_lsb(input int num_btn, input int sw_w, input int arg_w);
        return arg_w + sw_w + num_btn;
    endfunction

    function automatic int step_word_w(input int num_btn, input int sw_w, input int arg_w);
        return 2 + num_btn + sw_w + arg_w;
    endfunction

    function automatic logic [FIELD_MAX-1:0] field_mask(input int w);
        logic [FIELD_MAX-1:0] m;
        if (w >= FIELD_MAX) m = '1;
        else                m = (32'd1 << w) - 32'd1;
        return m;
    endfunction

    // The reserved opcode decodes as END, so a stray 2'b11 simply stops playback.
    function automatic stim_step_t decode_step(input logic [WORD_MAX-1:0] word,
                                               input int num_btn,
                                               input int sw_w,
                                               input int arg_w);
        stim_step_t           s;
        logic [WORD_MAX-1:0]  w;
        s.arg = word[FIELD_MAX-1:0] & field_mask(arg_w);
        w     = word >> sw_lsb(arg_w);
        s.sw  = w[FIELD_MAX-1:0] & field_mask(sw_w);
        w     = word >> btn_lsb(arg_w, sw_w);
        s.btn = w[FIELD_MAX-1:0] & field_mask(num_btn);
        w     = word >> op_lsb(num_btn, sw_w, arg_w);
        case (w[1:0])
            2'b01:   s.op = OP_HOLD;
            2'b10:   s.op = OP_WAIT;
            default: s.op = OP_END;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/slc3_stim_mem.sv
// Step memory for the stimulus player.
// It has a write port whose enable is gated by the caller and an
// asynchronous read port. Reset clears every entry, so an unprogrammed
// memory reads as END.
import slc3_stim_pkg::*;

module slc3_stim_mem #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Register array: cleared on reset, written on the edge when we is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/slc3_stim_player.sv
// Button/switch sequencer for the SLC-3 top level. It plays a list of steps
// that drive the active-low buttons and the switch bank. Each step either
// lasts a fixed number of cycles or waits until a watched CPU value matches.
//
// state | meaning
// IDLE  | stopped after reset or Abort; buttons released
// HOLD  | driving the current step for a fixed cycle count
// WAIT  | driving the current step until Watch == arg or timeout
// DONE  | run finished (END, implicit END or timeout); buttons released
import slc3_stim_pkg::*;

module slc3_stim_player #(
    parameter int NUM_BTN = 2,
    parameter int SW_W    = 10,
    parameter int DEPTH   = 16,
    parameter int ARG_W   = 16,
    parameter int TMO     = 1024
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            Start,
    input  logic                            Abort,
    input  logic                            Wr_En,
    input  logic [$clog2(DEPTH)-1:0]        Wr_Addr,
    input  logic [2+NUM_BTN+SW_W+ARG_W-1:0] Wr_Data,
    input  logic [ARG_W-1:0]                Watch,
    output logic [NUM_BTN-1:0]              Btn_n,
    output logic [SW_W-1:0]                 SW,
    output logic                            Busy,
    output logic                            Done,
    output logic                            Timeout,
    output logic [$clog2(DEPTH)-1:0]        Step_Idx
);

    localparam int AW     = $clog2(DEPTH);
    localparam int WORD_W = step_word_w(NUM_BTN, SW_W, ARG_W);
    localparam int TMO_W  = $clog2(TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);

    stim_state_t        state;
    logic [ARG_W-1:0]   hold_cnt;
    logic [ARG_W-1:0]   cur_arg;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               wr_ok;
    logic [AW-1:0]      rd_addr;
    logic [WORD_W-1:0]  rd_word;
    stim_step_t         nd;
    logic [NUM_BTN-1:0] nd_btn;
    logic [SW_W-1:0]    nd_sw;
    logic [ARG_W-1:0]   nd_arg;
    logic               go_start;
    logic               advance;
    logic               ends_run;
    logic               unused_dec;

    // Programming is allowed only while no step is executing.
    assign wr_ok = Wr_En && (state == ST_IDLE || state == ST_DONE);

    slc3_stim_mem #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_mem (
        .clk   (Clk),
        .rst_n (Reset),
        .we    (wr_ok),
        .waddr (Wr_Addr),
        .wdata (Wr_Data),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    // Look ahead to the step that would be entered at the next edge.
    always_comb begin
        go_start = Start && (state == ST_IDLE || state == ST_DONE);
        advance  = (state == ST_HOLD && hold_cnt == '0) ||
                   (state == ST_WAIT && Watch == cur_arg);
        rd_addr  = go_start ? '0 : Step_Idx + AW'(1);
        nd       = decode_step(WORD_MAX'(rd_word), NUM_BTN, SW_W, ARG_W);
        nd_btn   = nd.btn[NUM_BTN-1:0];
        nd_sw    = nd.sw[SW_W-1:0];
        nd_arg   = nd.arg[ARG_W-1:0];
        // Advancing past the last entry is an implicit END; there is no wrap.
        ends_run = (nd.op == OP_END) || (!go_start && Step_Idx == LAST_IDX);
    end

    assign unused_dec = ^{nd.btn, nd.sw, nd.arg};

    // Sequencer FSM with registered outputs, hold counter and timeout counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            Btn_n    <= '1;
            SW       <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Timeout  <= 1'b0;
            Step_Idx <= '0;
            hold_cnt <= '0;
            cur_arg  <= '0;
            tmo_cnt  <= '0;
        end else if (Abort) begin
            state    <= ST_IDLE;
            Btn_n    <= '1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Step_Idx <= '0;
        end else if (go_start || advance) begin
            if (go_start) Timeout <= 1'b0;
            if (ends_run) begin
                state <= ST_DONE;
                Btn_n <= '1;
                Busy  <= 1'b0;
                Done  <= 1'b1;
                if (go_start || Step_Idx != LAST_IDX) Step_Idx <= rd_addr;
            end else begin
                state    <= (nd.op == OP_HOLD) ? ST_HOLD : ST_WAIT;
                Btn_n    <= ~nd_btn;
                SW       <= nd_sw;
                Busy     <= 1'b1;
                Done     <= 1'b0;
                Step_Idx <= rd_addr;
                cur_arg  <= nd_arg;
                // A hold of 0 cycles is treated as 1 cycle.
                hold_cnt <= (nd_arg == '0) ? '0 : nd_arg - ARG_W'(1);
                tmo_cnt  <= TMO_LOAD;
            end
        end else if (state == ST_WAIT) begin
            if (tmo_cnt == '0) begin
                state   <= ST_DONE;
                Btn_n   <= '1;
                Busy    <= 1'b0;
                Done    <= 1'b1;
                Timeout <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
        end else if (state == ST_HOLD) begin
            hold_cnt <= hold_cnt - ARG_W'(1);
        end
    end

endmodule
